iserdes_deser_word: RTL and testbench

- Receive-side counterpart of the output serializer: converts a 1- or 2-bit-per-clock serial stream into DATA_WIDTH-bit parallel words.
- Words are presented with a single-cycle valid strobe.
- Bit order is the inverse of the transmit path: first bit received lands in Q[0], matching D1 sent first.
- Supports bit-slip word alignment for link bring-up ahead of the memory/IO capture logic.

---
 rtl/iserdes_deser_word_if.sv | 24 ++
 rtl/iserdes_deser_word.sv | 182 ++++++++++++++++++
 tb/tb_iserdes_deser_word.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/iserdes_deser_word_if.sv
// Bus bundle between the serial capture front end and the word deserializer.
interface iserdes_deser_word_if #(
  parameter int unsigned DATA_WIDTH = 4
);
  logic                  CE;
  logic                  DIN_R;
  logic                  DIN_F;
  logic                  BITSLIP;
  logic                  TRAIN;
  logic [DATA_WIDTH-1:0] Q;
  logic                  Q_VALID;
  logic                  LOCKED;
  logic                  SLIP_ERR;

  modport master (
    output CE, DIN_R, DIN_F, BITSLIP, TRAIN,
    input  Q, Q_VALID, LOCKED, SLIP_ERR
  );

  modport slave (
    input  CE, DIN_R, DIN_F, BITSLIP, TRAIN,
    output Q, Q_VALID, LOCKED, SLIP_ERR
  );
endinterface

// File: rtl/iserdes_deser_word.sv
// SDR/DDR serial-to-parallel word deserializer with bitslip; first received bit lands in Q[0].
// Define ISERDES_TRAINING_EN to add the automatic pattern-alignment FSM (TRAIN/LOCKED/SLIP_ERR).
module iserdes_deser_word #(
  parameter string       DATA_RATE     = "DDR",
  parameter int unsigned DATA_WIDTH    = 4,
  parameter bit          INIT_Q        = 1'b0,
  parameter logic [9:0]  TRAIN_PATTERN = 10'b0011010110
) (
  input logic                 CLK,
  input logic                 RST,
  iserdes_deser_word_if.slave bus
);

  localparam bit                IS_DDR   = (DATA_RATE == "DDR");
  localparam int unsigned       BUF_W    = 2 * DATA_WIDTH;
  localparam int unsigned       CNT_W    = $clog2(BUF_W);
  localparam logic [CNT_W-1:0]  WORD_CNT = CNT_W'(DATA_WIDTH);

  if ((DATA_RATE != "SDR") && (DATA_RATE != "DDR")) begin : g_bad_rate
    $fatal(1, "iserdes_deser_word: DATA_RATE must be SDR or DDR");
  end
  if ((DATA_WIDTH < 2) || (DATA_WIDTH > 10) || (DATA_WIDTH == 9)) begin : g_bad_width
    $fatal(1, "iserdes_deser_word: illegal DATA_WIDTH");
  end
  if (IS_DDR && ((DATA_WIDTH % 2) != 0)) begin : g_bad_ddr_width
    $fatal(1, "iserdes_deser_word: DDR needs an even DATA_WIDTH");
  end

  logic [BUF_W-1:0]      sr_q, sr_d, sr_base_c;
  logic [CNT_W-1:0]      cnt_q, cnt_d, cnt_base_c;
  logic [DATA_WIDTH-1:0] q_q, q_d;
  logic                  q_valid_q, q_valid_d;
  logic                  emit_c;
  logic                  slip_c;

  // Unread bits sit at sr[cnt-1:0], oldest at bit 0; a pending word is popped before new bits land.
  always_comb begin
    emit_c     = (cnt_q >= WORD_CNT);
    sr_base_c  = emit_c ? (sr_q >> DATA_WIDTH) : sr_q;
    cnt_base_c = emit_c ? (cnt_q - WORD_CNT) : cnt_q;
    sr_d       = sr_base_c;
    cnt_d      = cnt_base_c;
    if (bus.CE) begin
      if (IS_DDR) begin
        if (slip_c) begin
          sr_d[cnt_base_c] = bus.DIN_F;
          cnt_d            = cnt_base_c + CNT_W'(1);
        end else begin
          sr_d[cnt_base_c]             = bus.DIN_R;
          sr_d[cnt_base_c + CNT_W'(1)] = bus.DIN_F;
          cnt_d                        = cnt_base_c + CNT_W'(2);
        end
      end else if (!slip_c) begin
        sr_d[cnt_base_c] = bus.DIN_R;
        cnt_d            = cnt_base_c + CNT_W'(1);
      end
    end
    q_d       = emit_c ? sr_q[DATA_WIDTH-1:0] : q_q;
    q_valid_d = emit_c;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sr_q      <= '0;
      cnt_q     <= '0;
      q_q       <= {DATA_WIDTH{INIT_Q}};
      q_valid_q <= 1'b0;
    end else begin
      sr_q      <= sr_d;
      cnt_q     <= cnt_d;
      q_q       <= q_d;
      q_valid_q <= q_valid_d;
    end
  end

  assign bus.Q       = q_q;
  assign bus.Q_VALID = q_valid_q;

`ifdef ISERDES_TRAINING_EN
  typedef enum logic [2:0] {
    ST_IDLE, ST_CHECK, ST_SLIP, ST_SETTLE, ST_LOCK, ST_FAIL
  } train_state_e;

  localparam int unsigned           SC_W     = $clog2(DATA_WIDTH + 1);
  localparam logic [SC_W-1:0]       SLIP_MAX = SC_W'(DATA_WIDTH);
  localparam logic [DATA_WIDTH-1:0] PATTERN  = TRAIN_PATTERN[DATA_WIDTH-1:0];

  train_state_e    state_q, state_d;
  logic [SC_W-1:0] slipcnt_q, slipcnt_d;
  logic            settle_q, settle_d;
  logic            locked_q, locked_d;
  logic            slip_err_q, slip_err_d;
  logic            train_q;
  logic            train_rise_c;
  logic            train_slip_c;
  logic            train_busy_c;

  // Alignment search: compare a word, slip one bit, let two words flush, compare again.
  always_comb begin
    state_d      = state_q;
    slipcnt_d    = slipcnt_q;
    settle_d     = settle_q;
    locked_d     = locked_q;
    slip_err_d   = slip_err_q;
    train_slip_c = 1'b0;
    train_rise_c = bus.TRAIN && !train_q;
    train_busy_c = (state_q == ST_CHECK) || (state_q == ST_SLIP) || (state_q == ST_SETTLE);
    case (state_q)
      ST_IDLE, ST_LOCK, ST_FAIL: begin
        if (train_rise_c) begin
          state_d    = ST_CHECK;
          slipcnt_d  = '0;
          locked_d   = 1'b0;
          slip_err_d = 1'b0;
        end
      end
      ST_CHECK: begin
        if (q_valid_q) begin
          if (q_q == PATTERN) begin
            state_d  = ST_LOCK;
            locked_d = 1'b1;
          end else begin
            state_d = ST_SLIP;
          end
        end
      end
      ST_SLIP: begin
        if (bus.CE) begin
          train_slip_c = 1'b1;
          slipcnt_d    = slipcnt_q + SC_W'(1);
          settle_d     = 1'b0;
          if ((slipcnt_q + SC_W'(1)) == SLIP_MAX) begin
            state_d    = ST_FAIL;
            slip_err_d = 1'b1;
          end else begin
            state_d = ST_SETTLE;
          end
        end
      end
      ST_SETTLE: begin
        if (q_valid_q) begin
          settle_d = 1'b1;
          if (settle_q) begin
            state_d = ST_CHECK;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= ST_IDLE;
      slipcnt_q  <= '0;
      settle_q   <= 1'b0;
      locked_q   <= 1'b0;
      slip_err_q <= 1'b0;
      train_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      slipcnt_q  <= slipcnt_d;
      settle_q   <= settle_d;
      locked_q   <= locked_d;
      slip_err_q <= slip_err_d;
      train_q    <= bus.TRAIN;
    end
  end

  // The FSM owns the word boundary while it is searching.
  assign slip_c       = (bus.BITSLIP && !train_busy_c) || train_slip_c;
  assign bus.LOCKED   = locked_q;
  assign bus.SLIP_ERR = slip_err_q;
`else
  logic [10:0] unused_train;
  assign unused_train = {bus.TRAIN, TRAIN_PATTERN};
  assign slip_c       = bus.BITSLIP;
  assign bus.LOCKED   = 1'b0;
  assign bus.SLIP_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_iserdes_deser_word.sv
// Directed bench for iserdes_deser_word: SDR W=4, DDR W=8 and (with ISERDES_TRAINING_EN) training at W=10.
module tb_iserdes_deser_word;

  localparam logic [9:0] PAT = 10'b0011010110;

  logic CLK;
  logic RST;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  iserdes_deser_word_if #(.DATA_WIDTH(4)) s_if ();
  iserdes_deser_word_if #(.DATA_WIDTH(8)) d_if ();

  iserdes_deser_word #(.DATA_RATE("SDR"), .DATA_WIDTH(4), .INIT_Q(1'b1))
    u_sdr (.CLK(CLK), .RST(RST), .bus(s_if));
  iserdes_deser_word #(.DATA_RATE("DDR"), .DATA_WIDTH(8), .INIT_Q(1'b0))
    u_ddr (.CLK(CLK), .RST(RST), .bus(d_if));

`ifdef ISERDES_TRAINING_EN
  iserdes_deser_word_if #(.DATA_WIDTH(10)) t_if ();
  iserdes_deser_word #(.DATA_RATE("SDR"), .DATA_WIDTH(10), .INIT_Q(1'b0), .TRAIN_PATTERN(PAT))
    u_trn (.CLK(CLK), .RST(RST), .bus(t_if));
`endif

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // Strobed words and the cycle they appeared in
  logic [3:0] sq[$];
  int         st[$];
  logic [7:0] dq[$];
  int         dt[$];

  always @(negedge CLK) begin
    if (s_if.Q_VALID === 1'b1) begin sq.push_back(s_if.Q); st.push_back(cyc); end
    if (d_if.Q_VALID === 1'b1) begin dq.push_back(d_if.Q); dt.push_back(cyc); end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] sq_at(input int i);
    if (i < 0 || i >= sq.size()) return 4'hx;
    return sq[i];
  endfunction
  function automatic int st_at(input int i);
    if (i < 0 || i >= st.size()) return -1;
    return st[i];
  endfunction
  function automatic logic [7:0] dq_at(input int i);
    if (i < 0 || i >= dq.size()) return 8'hxx;
    return dq[i];
  endfunction
  function automatic int dt_at(input int i);
    if (i < 0 || i >= dt.size()) return -1;
    return dt[i];
  endfunction

  task automatic sdr_bit(input logic b, input logic slip);
    @(negedge CLK);
    s_if.CE = 1'b1; s_if.DIN_R = b; s_if.BITSLIP = slip;
  endtask
  task automatic sdr_idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      s_if.CE = 1'b0; s_if.BITSLIP = 1'b0;
    end
  endtask
  task automatic ddr_pair(input logic r, input logic f, input logic slip);
    @(negedge CLK);
    d_if.CE = 1'b1; d_if.DIN_R = r; d_if.DIN_F = f; d_if.BITSLIP = slip;
  endtask
  task automatic ddr_idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      d_if.CE = 1'b0; d_if.BITSLIP = 1'b0;
    end
  endtask

  int si = 0;
  // Repeating 0,0,0,1 stream; a slip still consumes its stream position
  task automatic stream(input int n, input logic slip_first);
    for (int i = 0; i < n; i++) begin
      sdr_bit((si % 4) == 3, slip_first && (i == 0));
      si++;
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog sim time exceeded checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] sbits;
    logic [7:0] dr;
    logic [7:0] df;
    logic [3:0] slip_exp[4];
    int         c_last;
    int         c_first;

    s_if.CE = 1'b0; s_if.DIN_R = 1'b0; s_if.DIN_F = 1'b0; s_if.BITSLIP = 1'b0; s_if.TRAIN = 1'b0;
    d_if.CE = 1'b0; d_if.DIN_R = 1'b0; d_if.DIN_F = 1'b0; d_if.BITSLIP = 1'b0; d_if.TRAIN = 1'b0;
`ifdef ISERDES_TRAINING_EN
    t_if.CE = 1'b0; t_if.DIN_R = 1'b0; t_if.DIN_F = 1'b0; t_if.BITSLIP = 1'b0; t_if.TRAIN = 1'b0;
`endif
    RST = 1'b0;

    // Reset values, held across edges
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("rst_q_sdr", s_if.Q, 4'hF);
    check("rst_v_sdr", s_if.Q_VALID, 0);
    check("rst_q_ddr", d_if.Q, 8'h00);
    check("rst_v_ddr", d_if.Q_VALID, 0);
    check("rst_locked", s_if.LOCKED, 0);
    check("rst_slip_err", s_if.SLIP_ERR, 0);
    RST = 1'b1;

    // SDR: 1,0,1,1 then 0,0,1,0
    sbits = 8'b0100_1101;
    c_first = 0;
    for (int i = 0; i < 8; i++) begin
      sdr_bit(sbits[i], 1'b0);
      if (i == 3) c_first = cyc;
    end
    sdr_idle(4);
    check("sdr_nwords", 32'(sq.size()), 2);
    check("sdr_word0", sq_at(0), 4'b1101);
    check("sdr_word1", sq_at(1), 4'b0100);
    check("sdr_latency", st_at(0), c_first + 2);
    check("sdr_spacing", st_at(1) - st_at(0), 4);
    sdr_idle(3);
    check("sdr_q_hold", s_if.Q, 4'b0100);
    check("sdr_v_low", s_if.Q_VALID, 0);

    // DDR: pairs (1,0)(0,1)(1,1)(0,0) then (0,1)(1,0)(1,0)(0,1)
    dr = 8'b0110_0101;
    df = 8'b1001_0110;
    for (int i = 0; i < 8; i++) begin
      ddr_pair(dr[i], df[i], 1'b0);
      if (i == 3) c_first = cyc;
    end
    ddr_idle(4);
    check("ddr_nwords", 32'(dq.size()), 2);
    check("ddr_word0", dq_at(0), 8'h39);
    check("ddr_word1", dq_at(1), 8'h96);
    check("ddr_latency", dt_at(0), c_first + 2);
    check("ddr_spacing", dt_at(1) - dt_at(0), 4);

    // DDR slip: only DIN_F kept, odd leftover carried into the next word
    dq.delete(); dt.delete();
    ddr_pair(1'b0, 1'b1, 1'b1);
    ddr_pair(1'b0, 1'b0, 1'b0);
    ddr_pair(1'b1, 1'b1, 1'b0);
    ddr_pair(1'b0, 1'b1, 1'b0);
    ddr_pair(1'b1, 1'b0, 1'b0);
    c_last = cyc;
    ddr_idle(3);
    check("ddr_slip_n", 32'(dq.size()), 1);
    check("ddr_slip_word", dq_at(0), 8'hD9);
    check("ddr_slip_lat", dt_at(0), c_last + 2);
    ddr_pair(1'b1, 1'b1, 1'b0);
    ddr_pair(1'b0, 1'b0, 1'b0);
    ddr_pair(1'b1, 1'b1, 1'b0);
    ddr_pair(1'b0, 1'b1, 1'b0);
    ddr_idle(3);
    check("ddr_carry_n", 32'(dq.size()), 2);
    check("ddr_carry_word", dq_at(1), 8'h66);

    // CE gap mid-word
    sq.delete(); st.delete();
    sdr_bit(1'b1, 1'b0);
    sdr_bit(1'b1, 1'b0);
    sdr_idle(3);
    sdr_bit(1'b0, 1'b0);
    sdr_bit(1'b1, 1'b0);
    c_last = cyc;
    sdr_idle(3);
    check("ce_gap_n", 32'(sq.size()), 1);
    check("ce_gap_word", sq_at(0), 4'b1011);
    check("ce_gap_lat", st_at(0), c_last + 2);

    // Reset mid-word: asynchronous clear, partial word dropped
    sq.delete(); st.delete();
    sdr_bit(1'b1, 1'b0);
    sdr_bit(1'b0, 1'b0);
    @(posedge CLK);
    #2 RST = 1'b0;
    s_if.CE = 1'b0;
    #1;
    check("rst_async_q", s_if.Q, 4'hF);
    check("rst_async_v", s_if.Q_VALID, 0);
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("rst_hold_q", s_if.Q, 4'hF);
    RST = 1'b1;
    sdr_bit(1'b0, 1'b0);
    sdr_bit(1'b1, 1'b0);
    sdr_bit(1'b1, 1'b0);
    sdr_bit(1'b0, 1'b0);
    sdr_idle(3);
    check("rst_mid_n", 32'(sq.size()), 1);
    check("rst_mid_word", sq_at(0), 4'b0110);

    // Bitslip walk on the 0001 stream
    stream(8, 1'b0);
    sdr_idle(3);
    check("slip0_word", sq_at(sq.size() - 1), 4'b1000);
    slip_exp[0] = 4'b0100;
    slip_exp[1] = 4'b0010;
    slip_exp[2] = 4'b0001;
    slip_exp[3] = 4'b1000;
    for (int k = 0; k < 4; k++) begin
      stream(12, 1'b1);
      sdr_idle(3);
      check($sformatf("slip%0d_word", k + 1), sq_at(sq.size() - 1), slip_exp[k]);
    end
    // BITSLIP without CE has no effect
    @(negedge CLK);
    s_if.CE = 1'b0; s_if.BITSLIP = 1'b1;
    @(negedge CLK);
    s_if.BITSLIP = 1'b0;
    stream(8, 1'b0);
    sdr_idle(3);
    check("slip_no_ce", sq_at(sq.size() - 1), 4'b1000);

    // Training status stays clear on an untrained link
    @(negedge CLK);
    s_if.TRAIN = 1'b1;
    @(negedge CLK);
    s_if.TRAIN = 1'b0;
    sdr_idle(3);
    check("untrained_locked", s_if.LOCKED, 0);
    check("untrained_err", s_if.SLIP_ERR, 0);

`ifdef ISERDES_TRAINING_EN
    begin
      logic [9:0] pat_v;
      logic [9:0] qlock;
      int         ti;
      bit         seen;
      pat_v = PAT;
      ti    = 0;
      seen  = 1'b0;
      qlock = '0;
      // Stream starts at PAT[3]: seven slips bring the boundary onto PAT[0]
      for (int n = 0; n < 3000 && !seen; n++) begin
        @(negedge CLK);
        if (t_if.LOCKED === 1'b1) begin
          seen = 1'b1; qlock = t_if.Q; t_if.CE = 1'b0; t_if.TRAIN = 1'b0;
        end else begin
          t_if.CE = 1'b1; t_if.DIN_R = pat_v[(ti + 3) % 10]; t_if.TRAIN = (n == 20); ti++;
        end
      end
      check("trn_locked", 32'(seen), 1);
      check("trn_q", qlock, PAT);
      check("trn_err_clear", t_if.SLIP_ERR, 0);
      for (int n = 0; n < 25; n++) begin
        @(negedge CLK);
        t_if.CE = 1'b1; t_if.DIN_R = pat_v[(ti + 3) % 10]; ti++;
      end
      @(negedge CLK);
      t_if.CE = 1'b0;
      repeat (3) @(negedge CLK);
      check("trn_lock_hold", t_if.LOCKED, 1);
      check("trn_q_hold", t_if.Q, PAT);

      // All-zero stream never matches
      seen = 1'b0;
      for (int n = 0; n < 4000 && !seen; n++) begin
        @(negedge CLK);
        if (t_if.SLIP_ERR === 1'b1) begin
          seen = 1'b1; t_if.CE = 1'b0; t_if.TRAIN = 1'b0;
        end else begin
          t_if.CE = 1'b1; t_if.DIN_R = 1'b0; t_if.TRAIN = (n == 2);
        end
      end
      check("trn_fail_err", 32'(seen), 1);
      check("trn_fail_locked", t_if.LOCKED, 0);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
